// File: rtl/shk_slave_responder.sv
// Shake-bus responder: captures one request per wvalid level, serves a job of dmosi cycles, answers with wready/smiso/dmiso.
// Latency: wready rises N+1 edges after the capturing edge; m_err_info1 is registered (1 cycle behind sticky/upstream).
// Backpressure: wready is held until the master drops wvalid, or until TIMEOUT_CYC cycles pass (then flagged and withdrawn).
module shk_slave_responder #(
    parameter int WD_SHK_SYNC = 16,
    parameter int WD_SHK_DLAY = 15,
    parameter int WD_ERR_INFO = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   s_shk_wvalid,
    input  logic [WD_SHK_SYNC-1:0] s_shk_smosi,
    input  logic [WD_SHK_DLAY-1:0] s_shk_dmosi,
    output logic                   s_shk_wready,
    output logic [WD_SHK_SYNC-1:0] s_shk_smiso,
    output logic [WD_SHK_DLAY-1:0] s_shk_dmiso,
    output logic                   o_job_busy,
    input  logic                   i_err_clr,
    input  logic [WD_ERR_INFO-1:0] s_err_info1,
    output logic [WD_ERR_INFO-1:0] m_err_info1
);

    localparam int WD_REL = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_REL-1:0] REL_LAST = WD_REL'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE,
        ST_RELEASE
    } state_t;

    state_t                 state_q, state_d;
    logic [WD_SHK_SYNC-1:0] tag_q, tag_d;
    logic [WD_SHK_DLAY-1:0] tgt_q, tgt_d;
    logic [WD_SHK_DLAY-1:0] cnt_q, cnt_d;
    logic [WD_REL-1:0]      rel_q, rel_d;
    logic [WD_SHK_SYNC-1:0] smiso_q, smiso_d;
    logic [WD_SHK_DLAY-1:0] dmiso_q, dmiso_d;
    logic [3:0]             err_q, err_d;
    logic [3:0]             err_set;
    logic [WD_ERR_INFO-1:0] merr_q, merr_d;

    always_comb begin
        state_d = state_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        rel_d   = rel_q;
        smiso_d = smiso_q;
        dmiso_d = dmiso_q;
        err_set = 4'b0000;
        case (state_q)
            ST_IDLE: begin
                if (s_shk_wvalid) begin
                    tag_d   = s_shk_smosi;
                    tgt_d   = s_shk_dmosi;
                    cnt_d   = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (!s_shk_wvalid) begin
                    state_d    = ST_IDLE;
                    err_set[2] = 1'b1;
                end else begin
                    if (s_shk_smosi != tag_q) begin
                        err_set[3] = 1'b1;
                    end
                    // Compare before incrementing so a full-scale N never wraps.
                    if (cnt_q == tgt_q) begin
                        state_d = ST_DONE;
                        smiso_d = tag_q;
                        dmiso_d = tgt_q;
                        rel_d   = '0;
                    end else begin
                        cnt_d = cnt_q + WD_SHK_DLAY'(1);
                    end
                end
            end
            ST_DONE: begin
                if (!s_shk_wvalid) begin
                    state_d = ST_IDLE;
                end else if (rel_q == REL_LAST) begin
                    state_d    = ST_RELEASE;
                    err_set[0] = 1'b1;
                end else begin
                    rel_d = rel_q + WD_REL'(1);
                end
            end
            ST_RELEASE: begin
                if (!s_shk_wvalid) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        err_d       = (i_err_clr ? 4'b0000 : err_q) | err_set;
        merr_d      = s_err_info1;
        merr_d[3:0] = s_err_info1[3:0] | err_q;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            tag_q   <= '0;
            tgt_q   <= '0;
            cnt_q   <= '0;
            rel_q   <= '0;
            smiso_q <= '0;
            dmiso_q <= '0;
            err_q   <= '0;
            merr_q  <= '0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
            rel_q   <= rel_d;
            smiso_q <= smiso_d;
            dmiso_q <= dmiso_d;
            err_q   <= err_d;
            merr_q  <= merr_d;
        end
    end

    assign s_shk_wready = (state_q == ST_DONE);
    assign o_job_busy   = (state_q == ST_BUSY);
    assign s_shk_smiso  = smiso_q;
    assign s_shk_dmiso  = dmiso_q;
    assign m_err_info1  = merr_q;

endmodule

// File: tb/tb_shk_slave_responder.sv
// Bench for shk_slave_responder: directed scenarios plus randomized jobs against a transaction-level model.
module tb_shk_slave_responder;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        wvalid;
    logic [15:0] smosi;
    logic [14:0] dmosi;
    logic        wready;
    logic [15:0] smiso;
    logic [14:0] dmiso;
    logic        busy;
    logic        err_clr;
    logic [3:0]  s_err;
    logic [3:0]  m_err;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_err = 4'b0000;

    logic [15:0] r_tag, r_mid;
    int          r_n, r_hold;
    logic [3:0]  r_s;

    shk_slave_responder #(
        .WD_SHK_SYNC(16),
        .WD_SHK_DLAY(15),
        .WD_ERR_INFO(4),
        .TIMEOUT_CYC(TO)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .s_shk_wvalid(wvalid),
        .s_shk_smosi (smosi),
        .s_shk_dmosi (dmosi),
        .s_shk_wready(wready),
        .s_shk_smiso (smiso),
        .s_shk_dmiso (dmiso),
        .o_job_busy  (busy),
        .i_err_clr   (err_clr),
        .s_err_info1 (s_err),
        .m_err_info1 (m_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", name, obs, exp);
        end
    endtask

    // A job of length n captured at edge k must show busy for edges k..k+n and wready exactly at k+n+1.
    task automatic run_job(input logic [15:0] tag, input int n, input logic [15:0] mid);
        wvalid = 1'b1;
        smosi  = tag;
        dmosi  = 15'(n);
        step();
        chk("cap_busy", 32'(busy), 32'd1);
        chk("cap_wready", 32'(wready), 32'd0);
        smosi = mid;
        if (mid != tag) exp_err[3] = 1'b1;
        for (int j = 1; j <= n; j++) begin
            step();
            chk("job_busy", 32'(busy), 32'd1);
            chk("job_wready", 32'(wready), 32'd0);
        end
        step();
        chk("done_wready", 32'(wready), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_smiso", 32'(smiso), 32'(tag));
        chk("done_dmiso", 32'(dmiso), 32'(n));
    endtask

    task automatic release_ok();
        wvalid = 1'b0;
        step();
        chk("rel_wready", 32'(wready), 32'd0);
    endtask

    task automatic clear_errs();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        exp_err = 4'b0000;
        step();
    endtask

    task automatic timeout_path();
        for (int j = 1; j < TO; j++) begin
            step();
            chk("to_hold", 32'(wready), 32'd1);
        end
        step();
        chk("to_drop", 32'(wready), 32'd0);
        exp_err[0] = 1'b1;
    endtask

    initial begin
        rst = 1'b1; wvalid = 1'b0; smosi = '0; dmosi = '0; err_clr = 1'b0; s_err = '0;
        step();
        step();
        chk("rst_wready", 32'(wready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_smiso", 32'(smiso), 32'd0);
        chk("rst_dmiso", 32'(dmiso), 32'd0);
        chk("rst_merr", 32'(m_err), 32'd0);
        rst = 1'b0;
        step();

        // T1
        run_job(16'hA5A5, 3, 16'hA5A5);
        release_ok();
        chk("t1_merr", 32'(m_err), 32'd0);

        // T2: zero-length then back-to-back request
        run_job(16'h7777, 0, 16'h7777);
        release_ok();
        run_job(16'h0001, 1, 16'h0001);
        release_ok();

        // T3: abort at edge 5, then clear takes two edges to reach the output
        wvalid = 1'b1; smosi = 16'h3C3C; dmosi = 15'd10;
        step();
        for (int j = 1; j <= 4; j++) step();
        wvalid = 1'b0;
        step();
        exp_err[2] = 1'b1;
        chk("t3_busy", 32'(busy), 32'd0);
        chk("t3_wready", 32'(wready), 32'd0);
        step();
        chk("t3_merr", 32'(m_err), 32'(exp_err));
        step();
        chk("t3_no_wready", 32'(wready), 32'd0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("t3_clr_1", 32'(m_err), 32'h4);
        step();
        exp_err = 4'b0000;
        chk("t3_clr_2", 32'(m_err), 32'h0);

        // T4: release timeout, no restart until wvalid seen low
        run_job(16'h5555, 2, 16'h5555);
        timeout_path();
        for (int j = 0; j < 3; j++) begin
            step();
            chk("t4_no_restart_busy", 32'(busy), 32'd0);
            chk("t4_no_restart_wr", 32'(wready), 32'd0);
        end
        chk("t4_merr", 32'(m_err), 32'(exp_err));
        wvalid = 1'b0;
        step();
        run_job(16'h6666, 1, 16'h6666);
        release_ok();
        clear_errs();
        chk("t4_clr", 32'(m_err), 32'd0);

        // T5: tag changed mid-job
        run_job(16'hBEEF, 6, 16'h1234);
        release_ok();
        step();
        chk("t5_merr", 32'(m_err), 32'h8);
        clear_errs();

        // Largest legal delay
        run_job(16'hCAFE, 32767, 16'hCAFE);
        release_ok();

        // Randomized jobs against the model
        for (int it = 0; it < 24; it++) begin
            r_tag  = 16'($urandom);
            r_n    = $urandom_range(0, 12);
            r_mid  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : r_tag;
            r_hold = $urandom_range(0, 20);
            run_job(r_tag, r_n, r_mid);
            if (r_hold < TO) begin
                for (int j = 0; j < r_hold; j++) begin
                    step();
                    chk("rnd_hold", 32'(wready), 32'd1);
                end
                release_ok();
            end else begin
                timeout_path();
                wvalid = 1'b0;
                step();
            end
            r_s   = 4'($urandom);
            s_err = r_s;
            step();
            step();
            chk("rnd_merr", 32'(m_err), 32'(exp_err | r_s));
            if ($urandom_range(0, 1) == 1) begin
                clear_errs();
                chk("rnd_clr", 32'(m_err), 32'(r_s));
            end
            s_err = 4'b0000;
            step();
        end

        // T6: async reset mid-job
        run_job(16'h0F0F, 0, 16'h0F0E);
        release_ok();
        step();
        chk("t6_pre_merr", 32'(m_err), 32'(exp_err));
        wvalid = 1'b1; smosi = 16'h2222; dmosi = 15'd20;
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_wready", 32'(wready), 32'd0);
        chk("t6_merr", 32'(m_err), 32'd0);
        chk("t6_smiso", 32'(smiso), 32'd0);
        wvalid = 1'b0;
        exp_err = 4'b0000;
        step();
        rst = 1'b0;
        s_err = 4'b0010;
        step();
        chk("t6_upstream", 32'(m_err), 32'h2);
        s_err = 4'b0000;
        step();
        chk("t6_not_sticky", 32'(m_err), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
